// File: rtl/whack_game_ctrl_if.sv
// Control/status bundle between the whack-a-mole game controller and its
// surrounding board logic (buttons, PRNG, tick source, display drivers).
interface whack_game_ctrl_if #(
  parameter int N_MOLES = 8,
  parameter int IDXW    = 3
);
  logic               tick_1hz;
  logic               start_pulse;
  logic [N_MOLES-1:0] btn_release;
  logic [IDXW-1:0]    rnd;
  logic [N_MOLES-1:0] mole_leds;
  logic [15:0]        score;
  logic [3:0]         seconds_left;
  logic [7:0]         round_num;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport master (
    output tick_1hz, start_pulse, btn_release, rnd,
    input  mole_leds, score, seconds_left, round_num, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  tick_1hz, start_pulse, btn_release, rnd,
    output mole_leds, score, seconds_left, round_num, hit_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole round sequencer: picks a mole per round, times the round,
// scores hits and wrong presses, and counts rounds until the game ends.
module whack_game_ctrl #(
  parameter int unsigned N_MOLES      = 8,
  parameter int unsigned ROUND_SEC    = 6,
  parameter int unsigned N_ROUNDS     = 10,
  parameter int unsigned SCORE_MULT   = 1,
  parameter int unsigned MISS_PENALTY = 0,
  parameter int unsigned SCORE_MAX    = 9999
) (
  input  logic             clk,
  input  logic             rst,
  whack_game_ctrl_if.slave bus
);
  localparam int IDXW = (N_MOLES > 2) ? $clog2(N_MOLES) : 1;

  typedef enum logic [2:0] {IDLE, ARM, ACTIVE, NEXT, DONE} state_t;

  state_t             state_r;
  logic [IDXW-1:0]    idx_r;
  logic               prev_valid_r;
  logic [15:0]        score_r;
  logic [3:0]         seconds_r;
  logic [7:0]         round_r;
  logic [N_MOLES-1:0] leds_r;
  logic               hit_r;
  logic               miss_r;
  logic               game_over_r;

  logic [IDXW-1:0]    rnd_mod_s;
  logic [IDXW-1:0]    arm_idx_s;
  logic               hit_s;
  logic [31:0]        score_add_s;
  logic [15:0]        score_hit_s;
  logic [15:0]        score_wrong_s;

  // Next-mole pick with repeat avoidance, and saturating/flooring score math
  always_comb begin
    rnd_mod_s     = IDXW'(32'(bus.rnd) % 32'(N_MOLES));
    arm_idx_s     = rnd_mod_s;
    hit_s         = bus.btn_release[idx_r];
    score_add_s   = 32'(score_r) + 32'(SCORE_MULT);
    score_hit_s   = score_r;
    score_wrong_s = score_r;
    if (prev_valid_r && (rnd_mod_s == idx_r)) begin
      arm_idx_s = (rnd_mod_s == IDXW'(N_MOLES - 1)) ? IDXW'(0) : rnd_mod_s + IDXW'(1);
    end else begin
      arm_idx_s = rnd_mod_s;
    end
    if (score_add_s > 32'(SCORE_MAX)) begin
      score_hit_s = 16'(SCORE_MAX);
    end else begin
      score_hit_s = 16'(score_add_s);
    end
    if (32'(score_r) >= 32'(MISS_PENALTY)) begin
      score_wrong_s = 16'(32'(score_r) - 32'(MISS_PENALTY));
    end else begin
      score_wrong_s = 16'd0;
    end
  end

  // Game FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      prev_valid_r <= 1'b0;
      score_r      <= 16'd0;
      seconds_r    <= 4'd0;
      round_r      <= 8'd0;
      leds_r       <= '0;
      hit_r        <= 1'b0;
      miss_r       <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start_pulse) begin
            score_r      <= 16'd0;
            round_r      <= 8'd0;
            prev_valid_r <= 1'b0;
            game_over_r  <= 1'b0;
            state_r      <= ARM;
          end
        end
        ARM: begin
          idx_r        <= arm_idx_s;
          prev_valid_r <= 1'b1;
          seconds_r    <= 4'(ROUND_SEC);
          leds_r       <= N_MOLES'(1) << arm_idx_s;
          state_r      <= ACTIVE;
        end
        ACTIVE: begin
          // A hit outranks both a coincident tick and any other pressed buttons
          if (hit_s) begin
            score_r <= score_hit_s;
            hit_r   <= 1'b1;
            leds_r  <= '0;
            state_r <= NEXT;
          end else begin
            if (|bus.btn_release) begin
              score_r <= score_wrong_s;
            end
            if (bus.tick_1hz) begin
              if (seconds_r > 4'd1) begin
                seconds_r <= seconds_r - 4'd1;
              end else begin
                seconds_r <= 4'd0;
                miss_r    <= 1'b1;
                leds_r    <= '0;
                state_r   <= NEXT;
              end
            end
          end
        end
        NEXT: begin
          round_r <= round_r + 8'd1;
          if ((round_r + 8'd1) == 8'(N_ROUNDS)) begin
            game_over_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= ARM;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mole_leds    = leds_r;
  assign bus.score        = score_r;
  assign bus.seconds_left = seconds_r;
  assign bus.round_num    = round_r;
  assign bus.hit_pulse    = hit_r;
  assign bus.miss_pulse   = miss_r;
  assign bus.game_over    = game_over_r;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// Lockstep bench: three differently parameterised controllers share a clock and
// are compared every step against a rule-level game model.
module tb_whack_game_ctrl;
  localparam int NI = 3;
  localparam int P_NM   [NI] = '{8, 5, 6};
  localparam int P_RS   [NI] = '{6, 3, 2};
  localparam int P_NR   [NI] = '{10, 2, 2};
  localparam int P_MULT [NI] = '{1, 1, 5000};
  localparam int P_PEN  [NI] = '{0, 2, 0};
  localparam int P_MAX  [NI] = '{9999, 9999, 9999};

  localparam int PH_IDLE = 0, PH_ARM = 1, PH_PLAY = 2, PH_NEXT = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  int m_phase [NI];
  int m_mole [NI];
  int m_prev [NI];
  int m_score [NI];
  int m_secs [NI];
  int m_rounds [NI];
  bit m_hit [NI];
  bit m_miss [NI];

  always #5 clk = ~clk;

  whack_game_ctrl_if #(.N_MOLES(8), .IDXW(3)) bus0 ();
  whack_game_ctrl_if #(.N_MOLES(5), .IDXW(3)) bus1 ();
  whack_game_ctrl_if #(.N_MOLES(6), .IDXW(3)) bus2 ();

  whack_game_ctrl #(.N_MOLES(8), .ROUND_SEC(6), .N_ROUNDS(10), .SCORE_MULT(1),
                    .MISS_PENALTY(0), .SCORE_MAX(9999))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  whack_game_ctrl #(.N_MOLES(5), .ROUND_SEC(3), .N_ROUNDS(2), .SCORE_MULT(1),
                    .MISS_PENALTY(2), .SCORE_MAX(9999))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  whack_game_ctrl #(.N_MOLES(6), .ROUND_SEC(2), .N_ROUNDS(2), .SCORE_MULT(5000),
                    .MISS_PENALTY(0), .SCORE_MAX(9999))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [46:0] obs_vec(input int i);
    case (i)
      0: obs_vec = {8'h00, bus0.mole_leds, bus0.score, bus0.seconds_left, bus0.round_num,
                    bus0.hit_pulse, bus0.miss_pulse, bus0.game_over};
      1: obs_vec = {11'h000, bus1.mole_leds, bus1.score, bus1.seconds_left, bus1.round_num,
                    bus1.hit_pulse, bus1.miss_pulse, bus1.game_over};
      default: obs_vec = {10'h000, bus2.mole_leds, bus2.score, bus2.seconds_left, bus2.round_num,
                          bus2.hit_pulse, bus2.miss_pulse, bus2.game_over};
    endcase
  endfunction

  function automatic logic [46:0] exp_vec(input int i);
    logic [15:0] leds;
    leds = (m_phase[i] == PH_PLAY) ? (16'd1 << m_mole[i]) : 16'd0;
    exp_vec = {leds, 16'(m_score[i]), 4'(m_secs[i]), 8'(m_rounds[i]),
               m_hit[i], m_miss[i], (m_phase[i] == PH_DONE)};
  endfunction

  function automatic logic [15:0] hit_btn(input int i);
    hit_btn = (m_phase[i] == PH_PLAY) ? (16'd1 << m_mole[i]) : 16'd0;
  endfunction

  function automatic logic [15:0] wrong_btn(input int i);
    wrong_btn = 16'd1 << ((m_mole[i] + 1) % P_NM[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_phase[i] = PH_IDLE; m_mole[i] = 0; m_prev[i] = -1; m_score[i] = 0;
      m_secs[i] = 0; m_rounds[i] = 0; m_hit[i] = 1'b0; m_miss[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit start, input bit tick, input int r,
                            input logic [15:0] btn);
    int n;
    int b;
    int pick;
    n = P_NM[i];
    b = int'(btn) & ((1 << n) - 1);
    m_hit[i] = 1'b0;
    m_miss[i] = 1'b0;
    if (m_phase[i] == PH_IDLE || m_phase[i] == PH_DONE) begin
      if (start) begin
        m_score[i] = 0; m_rounds[i] = 0; m_prev[i] = -1; m_phase[i] = PH_ARM;
      end
    end else if (m_phase[i] == PH_ARM) begin
      pick = r % n;
      if (m_prev[i] >= 0 && pick == m_prev[i]) pick = (pick + 1) % n;
      m_mole[i] = pick; m_prev[i] = pick; m_secs[i] = P_RS[i]; m_phase[i] = PH_PLAY;
    end else if (m_phase[i] == PH_PLAY) begin
      if (((b >> m_mole[i]) & 1) == 1) begin
        m_score[i] = (m_score[i] + P_MULT[i] > P_MAX[i]) ? P_MAX[i] : m_score[i] + P_MULT[i];
        m_hit[i] = 1'b1;
        m_phase[i] = PH_NEXT;
      end else begin
        if (b != 0) m_score[i] = (m_score[i] < P_PEN[i]) ? 0 : m_score[i] - P_PEN[i];
        if (tick) begin
          if (m_secs[i] > 1) m_secs[i] = m_secs[i] - 1;
          else begin
            m_secs[i] = 0; m_miss[i] = 1'b1; m_phase[i] = PH_NEXT;
          end
        end
      end
    end else begin
      m_rounds[i] = m_rounds[i] + 1;
      m_phase[i] = (m_rounds[i] == P_NR[i]) ? PH_DONE : PH_ARM;
    end
  endtask

  task automatic drive(input bit start, input bit tick, input int r,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    logic [2:0] r3;
    r3 = 3'(r);
    bus0.start_pulse = start; bus1.start_pulse = start; bus2.start_pulse = start;
    bus0.tick_1hz = tick; bus1.tick_1hz = tick; bus2.tick_1hz = tick;
    bus0.rnd = r3; bus1.rnd = r3; bus2.rnd = r3;
    bus0.btn_release = b0[7:0]; bus1.btn_release = b1[4:0]; bus2.btn_release = b2[5:0];
  endtask

  // One clock edge: inputs held across the edge, model advanced, inputs cleared at edge+1
  task automatic step(input bit start, input bit tick, input int r,
                      input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    drive(start, tick, r, b0, b1, b2);
    @(posedge clk);
    model_step(0, start, tick, r & 7, b0);
    model_step(1, start, tick, r & 7, b1);
    model_step(2, start, tick, r & 7, b2);
    #1;
    drive(1'b0, 1'b0, 0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 0, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== 47'd0) begin
        errors++; $display("FAIL reset_state inst%0d got %h exp 0", i, obs_vec(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 3, 16'hffff, 16'hffff, 16'hffff);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL idle_ignores_inputs inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_first_round();
    step(1'b1, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus0.mole_leds !== 8'h08 || bus0.seconds_left !== 4'd6) begin
      errors++; $display("FAIL first_mole got leds %h secs %0d exp leds 08 secs 6",
                         bus0.mole_leds, bus0.seconds_left);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL first_round inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_hit();
    step(1'b0, 1'b0, 3, hit_btn(0), hit_btn(1), hit_btn(2));
    checks++;
    if (bus0.hit_pulse !== 1'b1 || bus0.score !== 16'd1 || bus0.miss_pulse !== 1'b0) begin
      errors++; $display("FAIL hit_strobe got hit %b miss %b score %0d exp hit 1 miss 0 score 1",
                         bus0.hit_pulse, bus0.miss_pulse, bus0.score);
    end
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus0.hit_pulse !== 1'b0 || bus0.round_num !== 8'd1) begin
      errors++; $display("FAIL hit_next got hit %b round %0d exp hit 0 round 1",
                         bus0.hit_pulse, bus0.round_num);
    end
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus0.mole_leds !== 8'h10) begin
      errors++; $display("FAIL repeat_avoid got leds %h exp 10", bus0.mole_leds);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL hit_round inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, int'($urandom_range(7)), 16'd0, 16'd0, 16'd0);
      checks++;
      if (bus0.seconds_left !== 4'((k < 6) ? 6 - k : 0) || bus0.miss_pulse !== (k == 6)) begin
        errors++; $display("FAIL countdown tick%0d got secs %0d miss %b exp secs %0d miss %b", k,
                           bus0.seconds_left, bus0.miss_pulse, (k < 6) ? 6 - k : 0, k == 6);
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL countdown inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
        end
      end
      step(1'b0, 1'b0, int'($urandom_range(7)), 16'd0, 16'd0, 16'd0);
    end
    checks++;
    if (bus0.round_num !== 8'd2 || bus0.score !== 16'd1 || bus0.miss_pulse !== 1'b0) begin
      errors++; $display("FAIL miss_round got round %0d score %0d miss %b exp round 2 score 1 miss 0",
                         bus0.round_num, bus0.score, bus0.miss_pulse);
    end
  endtask

  task automatic test_penalty();
    do_reset();
    step(1'b1, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, hit_btn(0), hit_btn(1), hit_btn(2));
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b0, 3, wrong_btn(0), wrong_btn(1), wrong_btn(2));
      checks++;
      if (bus1.score !== 16'd0 || bus1.mole_leds !== 5'(hit_btn(1)) || bus1.hit_pulse !== 1'b0) begin
        errors++; $display("FAIL penalty_floor press%0d got score %0d leds %h hit %b exp score 0 leds %h hit 0",
                           n, bus1.score, bus1.mole_leds, bus1.hit_pulse, 5'(hit_btn(1)));
      end
    end
    step(1'b0, 1'b1, 3, hit_btn(0), hit_btn(1), hit_btn(2));
    checks++;
    if (bus1.hit_pulse !== 1'b1 || bus1.seconds_left !== 4'd3 || bus1.miss_pulse !== 1'b0
        || bus1.score !== 16'd1 || bus0.seconds_left !== 4'd6) begin
      errors++; $display("FAIL hit_beats_tick got hit %b miss %b secs %0d/%0d score %0d exp 1 0 3/6 1",
                         bus1.hit_pulse, bus1.miss_pulse, bus1.seconds_left, bus0.seconds_left, bus1.score);
    end
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL penalty_game inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_done_saturate();
    do_reset();
    step(1'b1, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    step(1'b1, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL start_ignored inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
    step(1'b0, 1'b0, 5, hit_btn(0), hit_btn(1), hit_btn(2));
    step(1'b0, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5, hit_btn(0), hit_btn(1), hit_btn(2));
    step(1'b0, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus1.game_over !== 1'b1 || bus1.score !== 16'd2 || bus2.game_over !== 1'b1
        || bus2.score !== 16'd9999 || bus0.game_over !== 1'b0) begin
      errors++; $display("FAIL game_done got over %b/%b/%b score %0d/%0d exp over 0/1/1 score 2/9999",
                         bus0.game_over, bus1.game_over, bus2.game_over, bus1.score, bus2.score);
    end
    step(1'b0, 1'b1, 5, 16'hffff, 16'hffff, 16'hffff);
    checks++;
    if (bus1.score !== 16'd2 || bus2.score !== 16'd9999 || bus2.game_over !== 1'b1) begin
      errors++; $display("FAIL done_hold got score %0d/%0d over %b exp 2/9999 over 1",
                         bus1.score, bus2.score, bus2.game_over);
    end
    step(1'b1, 1'b0, 5, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus2.score !== 16'd0 || bus2.game_over !== 1'b0 || bus2.round_num !== 8'd0) begin
      errors++; $display("FAIL restart got score %0d over %b round %0d exp 0 0 0",
                         bus2.score, bus2.game_over, bus2.round_num);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL restart_lockstep inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== 47'd0) begin
        errors++; $display("FAIL async_reset inst%0d got %h exp 0", i, obs_vec(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 3, 16'd0, 16'd0, 16'd0);
    checks++;
    if (bus0.mole_leds !== 8'h08) begin
      errors++; $display("FAIL fresh_game_no_avoid got leds %h exp 08", bus0.mole_leds);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL fresh_game inst%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] b [NI];
    int sel;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399) == 0) do_reset();
      for (int i = 0; i < NI; i++) begin
        sel = int'($urandom_range(5));
        if (sel < 2) b[i] = hit_btn(i);
        else if (sel == 2) b[i] = 16'($urandom);
        else b[i] = 16'd0;
      end
      step($urandom_range(7) == 0, $urandom_range(3) == 0, int'($urandom_range(7)), b[0], b[1], b[2]);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL random cyc%0d inst%0d got %h exp %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_hit();
    test_timeout();
    test_penalty();
    test_done_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
